spike_window_ctrl: RTL and testbench

Sequencing controller for the output-spike stage of the ODESA classifier. Each input spike opens a bounded decision window. During the window the controller selects one winning output-neuron spike, breaking ties by lowest index. It emits a single registered one-hot output pulse plus the winner index, or a timeout pulse if no neuron fires. A hold-off period follows each decision so the downstream layer and label logic see at most one decision per input event.

---
 rtl/odesa_pkg.sv | 24 ++
 rtl/spike_prio_enc.sv | 36 +++
 rtl/spike_window_ctrl.sv | 149 ++++++++++++++
 tb/tb_spike_window_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/odesa_pkg.sv
// ----------------------------------------------------------------------------
// odesa_pkg
// Shared definitions for the ODESA output-spike stage.
//   state_t       : controller state encoding (ST_IDLE, ST_WAIT, ST_FIRE, ST_HOLD)
//   idx_width()   : width of an index that must hold 0 ("none") up to n
// No ports; imported by spike_prio_enc and spike_window_ctrl.
// ----------------------------------------------------------------------------
package odesa_pkg;

    // Controller states. IDLE is the reset state and the only non-busy state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FIRE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Index vectors carry 1..n plus 0 meaning "no spike", so they need
    // enough bits for n+1 distinct values. Never returns less than one bit.
    function automatic int idx_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// ----------------------------------------------------------------------------
// spike_prio_enc
// Purely combinational priority encoder: the lowest-index set bit wins.
// Ports:
//   spike_vec  [p_num:1]  input  neuron spike vector, any number of bits high
//   win_idx    idx width  output winning index 1..p_num, 0 when none set
//   win_onehot [p_num:1]  output one-hot of the winner, all zero when none
// ----------------------------------------------------------------------------
module spike_prio_enc
    import odesa_pkg::*;
#(
    parameter int p_num = 10,
    localparam int c_idx_w = idx_width(p_num)
) (
    input  logic [p_num:1]     spike_vec,
    output logic [c_idx_w-1:0] win_idx,
    output logic [p_num:1]     win_onehot
);

    // Scan upward and stop recording after the first hit, so the lowest
    // index always wins a tie.
    always_comb begin
        logic found;
        found      = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 1; i <= p_num; i++) begin
            if (spike_vec[i] && !found) begin
                found         = 1'b1;
                win_idx       = c_idx_w'(i);
                win_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_window_ctrl.sv
// ----------------------------------------------------------------------------
// spike_window_ctrl
// Decision-window sequencer for the ODESA output-spike stage. Each input
// event opens a window of p_window cycles; the first neuron spike in the
// window (lowest index on ties) becomes a single registered winner pulse,
// otherwise a timeout pulse is emitted. A hold-off follows each decision.
// Ports:
//   i_clk       in   clock, rising edge
//   i_rst_n     in   synchronous active-low reset
//   i_spike_in  in   input-event strobe, opens/restarts a window
//   i_spike     in   [p_num:1] neuron spike vector
//   o_spike     out  [p_num:1] one-hot winner pulse (one cycle)
//   o_winner    out  winner index 1..p_num, 0 otherwise
//   o_valid     out  pulse coincident with o_spike
//   o_timeout   out  pulse when a window expires without a neuron spike
//   o_busy      out  high whenever the controller is not idle
//   o_drop      out  pulse one cycle after an ignored i_spike_in
// ----------------------------------------------------------------------------
module spike_window_ctrl
    import odesa_pkg::*;
#(
    parameter int p_num     = 10,
    parameter int p_window  = 8,
    parameter int p_holdoff = 2,
    localparam int c_idx_w  = idx_width(p_num)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_spike_in,
    input  logic [p_num:1]     i_spike,
    output logic [p_num:1]     o_spike,
    output logic [c_idx_w-1:0] o_winner,
    output logic               o_valid,
    output logic               o_timeout,
    output logic               o_busy,
    output logic               o_drop
);

    localparam int c_win_w  = idx_width(p_window);
    localparam int c_hold_w = idx_width(p_holdoff);

    state_t              state;
    logic [c_win_w-1:0]  win_cnt;
    logic [c_hold_w-1:0] hold_cnt;
    logic [c_idx_w-1:0]  win_idx;
    logic [p_num:1]      win_onehot;

    logic [c_idx_w-1:0]  enc_idx;
    logic [p_num:1]      enc_onehot;

    // Lowest-index winner of the current neuron spike vector.
    spike_prio_enc #(
        .p_num (p_num)
    ) u_prio_enc (
        .spike_vec  (i_spike),
        .win_idx    (enc_idx),
        .win_onehot (enc_onehot)
    );

    // Single FSM with every output registered. Pulse outputs default to 0
    // each cycle and are raised only on the transition that produces them.
    // The window counter holds the number of samples left including the
    // current one, so a value of 1 marks the last sample of the window.
    // HOLD lasts p_holdoff+1 cycles: the decision pulse cycle plus the
    // hold-off proper. o_busy is simply "next state is not IDLE".
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            win_cnt    <= '0;
            hold_cnt   <= '0;
            win_idx    <= '0;
            win_onehot <= '0;
            o_spike    <= '0;
            o_winner   <= '0;
            o_valid    <= 1'b0;
            o_timeout  <= 1'b0;
            o_busy     <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            o_spike   <= '0;
            o_winner  <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            o_drop    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (i_spike_in) begin
                        state   <= ST_WAIT;
                        win_cnt <= c_win_w'(p_window);
                        o_busy  <= 1'b1;
                    end else begin
                        o_busy  <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    o_busy <= 1'b1;
                    if (enc_idx != '0) begin
                        win_idx    <= enc_idx;
                        win_onehot <= enc_onehot;
                        state      <= ST_FIRE;
                        o_drop     <= i_spike_in;
                    end else if (i_spike_in) begin
                        win_cnt <= c_win_w'(p_window);
                    end else if (win_cnt == c_win_w'(1)) begin
                        o_timeout <= 1'b1;
                        state     <= ST_HOLD;
                        hold_cnt  <= c_hold_w'(p_holdoff);
                    end else begin
                        win_cnt <= win_cnt - c_win_w'(1);
                    end
                end

                ST_FIRE: begin
                    o_spike  <= win_onehot;
                    o_winner <= win_idx;
                    o_valid  <= 1'b1;
                    o_drop   <= i_spike_in;
                    if (p_holdoff == 0) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        state    <= ST_HOLD;
                        hold_cnt <= c_hold_w'(p_holdoff);
                        o_busy   <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    o_drop <= i_spike_in;
                    if (hold_cnt == '0) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - c_hold_w'(1);
                        o_busy   <= 1'b1;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_window_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spike_window_ctrl
// Directed self-checking bench for spike_window_ctrl (p_num=10, p_window=8,
// p_holdoff=2). Each step drives the inputs for one rising edge and pushes
// the outputs expected during the following cycle into a scoreboard queue;
// the outputs are sampled on the falling edge and compared against it.
// ----------------------------------------------------------------------------
module tb_spike_window_ctrl;

    typedef struct packed {
        logic [10:1] spike;
        logic [3:0]  winner;
        logic        valid;
        logic        timeout;
        logic        busy;
        logic        drop;
    } out_t;

    typedef struct {
        out_t  exp;
        string tag;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        spike_in;
    logic [10:1] spike;
    logic [10:1] o_spike;
    logic [3:0]  o_winner;
    logic        o_valid;
    logic        o_timeout;
    logic        o_busy;
    logic        o_drop;

    sb_t sb_q[$];
    int  vectors;
    int  miscompares;

    spike_window_ctrl #(
        .p_num     (10),
        .p_window  (8),
        .p_holdoff (2)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_spike_in (spike_in),
        .i_spike    (spike),
        .o_spike    (o_spike),
        .o_winner   (o_winner),
        .o_valid    (o_valid),
        .o_timeout  (o_timeout),
        .o_busy     (o_busy),
        .o_drop     (o_drop)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds an expected output bundle.
    function automatic out_t mk(input logic [10:1] sp, input logic [3:0] w,
                                input logic v, input logic t,
                                input logic b, input logic d);
        out_t r;
        r.spike   = sp;
        r.winner  = w;
        r.valid   = v;
        r.timeout = t;
        r.busy    = b;
        r.drop    = d;
        return r;
    endfunction

    // Pops the oldest expectation and compares it with the sampled outputs.
    task automatic checkOutput();
        sb_t  e;
        out_t obs;
        obs = '{spike: o_spike, winner: o_winner, valid: o_valid,
                timeout: o_timeout, busy: o_busy, drop: o_drop};
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_empty: observed outputs %h, required a queued expectation", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed spike=%h winner=%0d valid=%b timeout=%b busy=%b drop=%b, expected spike=%h winner=%0d valid=%b timeout=%b busy=%b drop=%b",
                   e.tag, obs.spike, obs.winner, obs.valid, obs.timeout, obs.busy, obs.drop,
                   e.exp.spike, e.exp.winner, e.exp.valid, e.exp.timeout, e.exp.busy, e.exp.drop);
        end
    endtask

    // Drives one edge worth of inputs, records what the next cycle must
    // show, then samples on the falling edge.
    task automatic applyStimulus(input logic r, input logic si,
                                 input logic [10:1] sp, input out_t exp_v,
                                 input string tag);
        sb_t e;
        rst_n    = r;
        spike_in = si;
        spike    = sp;
        e.exp    = exp_v;
        e.tag    = tag;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        out_t idle_o;
        out_t busy_o;
        vectors     = 0;
        miscompares = 0;
        idle_o      = mk(10'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        busy_o      = mk(10'h000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n       = 1'b0;
        spike_in    = 1'b1;
        spike       = 10'h3FF;

        // Reset held with every input active.
        applyStimulus(1'b0, 1'b1, 10'h3FF, idle_o, "reset_0");
        applyStimulus(1'b0, 1'b1, 10'h3FF, idle_o, "reset_1");
        applyStimulus(1'b1, 1'b0, 10'h000, idle_o, "reset_release");

        // Single winner on the third window sample; later spikes ignored.
        applyStimulus(1'b1, 1'b1, 10'h000, busy_o, "single_open");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "single_w1");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "single_w2");
        applyStimulus(1'b1, 1'b0, 10'h040, busy_o, "single_w3");
        applyStimulus(1'b1, 1'b0, 10'h001,
                      mk(10'h040, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0), "single_fire");
        applyStimulus(1'b1, 1'b0, 10'h001, busy_o, "single_hold1");
        applyStimulus(1'b1, 1'b0, 10'h001, busy_o, "single_hold2");
        applyStimulus(1'b1, 1'b0, 10'h000, idle_o, "single_idle");

        // Tie between neurons 2 and 10.
        applyStimulus(1'b1, 1'b1, 10'h000, busy_o, "tie_open");
        applyStimulus(1'b1, 1'b0, 10'h202, busy_o, "tie_w1");
        applyStimulus(1'b1, 1'b0, 10'h000,
                      mk(10'h002, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0), "tie_fire");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "tie_hold1");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "tie_hold2");
        applyStimulus(1'b1, 1'b0, 10'h000, idle_o, "tie_idle");

        // Full window with no neuron spike.
        applyStimulus(1'b1, 1'b1, 10'h000, busy_o, "to_open");
        for (int i = 1; i <= 7; i++)
            applyStimulus(1'b1, 1'b0, 10'h000, busy_o, $sformatf("to_w%0d", i));
        applyStimulus(1'b1, 1'b0, 10'h000,
                      mk(10'h000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0), "to_w8");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "to_hold1");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "to_hold2");
        applyStimulus(1'b1, 1'b0, 10'h000, idle_o, "to_idle");

        // Restart on the fourth sample extends the window by 8 from there.
        applyStimulus(1'b1, 1'b1, 10'h000, busy_o, "rs_open");
        for (int i = 1; i <= 3; i++)
            applyStimulus(1'b1, 1'b0, 10'h000, busy_o, $sformatf("rs_w%0d", i));
        applyStimulus(1'b1, 1'b1, 10'h000, busy_o, "rs_restart");
        for (int i = 1; i <= 7; i++)
            applyStimulus(1'b1, 1'b0, 10'h000, busy_o, $sformatf("rs_x%0d", i));
        applyStimulus(1'b1, 1'b0, 10'h000,
                      mk(10'h000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0), "rs_x8");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "rs_hold1");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "rs_hold2");
        applyStimulus(1'b1, 1'b0, 10'h000, idle_o, "rs_idle");

        // Neuron spike together with i_spike_in, then i_spike_in during HOLD.
        applyStimulus(1'b1, 1'b1, 10'h000, busy_o, "dr_open");
        applyStimulus(1'b1, 1'b1, 10'h080,
                      mk(10'h000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), "dr_sim");
        applyStimulus(1'b1, 1'b0, 10'h000,
                      mk(10'h080, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0), "dr_fire");
        applyStimulus(1'b1, 1'b1, 10'h000,
                      mk(10'h000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), "dr_hold_drop");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "dr_hold2");
        applyStimulus(1'b1, 1'b0, 10'h000, idle_o, "dr_idle");
        applyStimulus(1'b1, 1'b0, 10'h000, idle_o, "dr_no_window");

        // Reset in the cycle a spike is sampled, then a normal event.
        applyStimulus(1'b1, 1'b1, 10'h000, busy_o, "mr_open");
        applyStimulus(1'b0, 1'b0, 10'h001, idle_o, "mr_reset");
        applyStimulus(1'b1, 1'b0, 10'h000, idle_o, "mr_release");
        applyStimulus(1'b1, 1'b1, 10'h000, busy_o, "mr_open2");
        applyStimulus(1'b1, 1'b0, 10'h010, busy_o, "mr_w1");
        applyStimulus(1'b1, 1'b0, 10'h000,
                      mk(10'h010, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0), "mr_fire");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "mr_hold1");
        applyStimulus(1'b1, 1'b0, 10'h000, busy_o, "mr_hold2");
        applyStimulus(1'b1, 1'b0, 10'h000, idle_o, "mr_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
